// File: rtl/axis_skid_pkg.sv
// axis_skid_pkg
//   Shared width helpers for the AXI-Stream elastic buffer.
//   level_width(depth) : bits needed to hold a fill level of 0..depth
//   ptr_width(depth)   : bits of a read/write pointer into depth entries
package axis_skid_pkg;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_fifo_ctrl.sv
// axis_skid_fifo_ctrl
//   Pointer, count and status bookkeeping for axis_skid_fifo. All status
//   outputs are registered from the next-state count, so they change on the
//   same edge as the push/pop that moves the count.
// Ports
//   clk, reset_done      : clock, async active-high reset
//   i_valid, i_ready     : upstream valid / downstream ready
//   i_flush              : synchronous discard, wins over push and pop
//   o_wr_en              : write strobe for the storage array this cycle
//   o_wr_ptr, o_rd_ptr   : storage array pointers
//   o_valid, o_ready     : registered handshake outputs
//   o_level              : entries stored
//   o_almost_full        : o_level >= AFULL_THRESH
module axis_skid_fifo_ctrl
    import axis_skid_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int AFULL_THRESH = DEPTH - 1,
    localparam int PW           = ptr_width(DEPTH),
    localparam int LW           = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_done,
    input  logic          i_valid,
    input  logic          i_ready,
    input  logic          i_flush,
    output logic          o_wr_en,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic          o_valid,
    output logic          o_ready,
    output logic [LW-1:0] o_level,
    output logic          o_almost_full
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q,  count_d;
    logic          valid_q,  valid_d;
    logic          ready_q,  ready_d;
    logic          afull_q,  afull_d;
    logic          push, pop;

    assign push = i_valid & ready_q;
    assign pop  = valid_q & i_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
        valid_d = (count_d != '0);
        ready_d = (count_d != LW'(DEPTH));
        afull_d = (count_d >= LW'(AFULL_THRESH));
    end

    // o_ready resets low and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset_done) begin
        if (reset_done) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            afull_q  <= afull_d;
        end
    end

    // A flushed push still handshakes upstream but never lands in storage.
    assign o_wr_en       = push & ~i_flush;
    assign o_wr_ptr      = wr_ptr_q;
    assign o_rd_ptr      = rd_ptr_q;
    assign o_valid       = valid_q;
    assign o_ready       = ready_q;
    assign o_level       = count_q;
    assign o_almost_full = afull_q;

endmodule

// File: rtl/axis_skid_fifo.sv
// axis_skid_fifo
//   Parametrised AXI-Stream elastic buffer carrying {last, data}. Breaks the
//   ready path between producer and consumer; every output comes from flops.
// Ports
//   clk, reset_done                 : clock, async active-high reset
//   i_valid, i_data, i_last, o_ready: upstream AXI-S slave side
//   o_valid, o_data, o_last, i_ready: downstream AXI-S master side
//   i_flush                         : synchronous discard of stored entries
//   o_level, o_almost_full          : fill level and threshold flag
module axis_skid_fifo
    import axis_skid_pkg::*;
#(
    parameter  int DWIDTH       = 8,
    parameter  int DEPTH        = 4,
    parameter  int AFULL_THRESH = DEPTH - 1,
    localparam int PW           = ptr_width(DEPTH),
    localparam int LW           = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_done,
    input  logic              i_valid,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    input  logic              i_flush,
    output logic [LW-1:0]     o_level,
    output logic              o_almost_full
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axis_skid_fifo: DEPTH must be a power of two and >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
        $error("axis_skid_fifo: AFULL_THRESH must be within 1..DEPTH");
    end

    typedef struct packed {
        logic              last;
        logic [DWIDTH-1:0] data;
    } axis_beat_t;

    axis_beat_t    mem_q [DEPTH];
    axis_beat_t    mem_d [DEPTH];
    logic          wr_en;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    axis_skid_fifo_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ctrl (
        .clk           (clk),
        .reset_done    (reset_done),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_flush       (i_flush),
        .o_wr_en       (wr_en),
        .o_wr_ptr      (wr_ptr),
        .o_rd_ptr      (rd_ptr),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_level       (o_level),
        .o_almost_full (o_almost_full)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = '{last: i_last, data: i_data};
        end
    end

    // Storage is deliberately unreset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_data = mem_q[rd_ptr].data;
    assign o_last = mem_q[rd_ptr].last;

endmodule

// File: doc/axis_skid_fifo.md
# axis_skid_fifo

Parametrised AXI-Stream elastic buffer, successor to the two-entry skid buffer. It generalises data width and depth, and adds packet boundary (last), fill-level reporting, an almost-full flag and a synchronous flush. It sits between any AXI-S producer and consumer to break the ready timing path and absorb backpressure bursts. Every output is driven from flops, and no combinational path exists from any input to any output.

## Interface
- DWIDTH, 8: payload width in bits, ≥1.
- DEPTH, 4: entries, power of two, ≥2.
- AFULL_THRESH, DEPTH-1: level at or above which o_almost_full asserts; range 1..DEPTH.
- clk  in  1  clock; all logic on the rising edge.
- reset_done  in  1  reset, asynchronous, active-high.
- i_valid  in  1  upstream valid.
- i_data  in  DWIDTH  upstream payload.
- i_last  in  1  upstream end-of-packet.
- o_ready  out  1  ready to upstream.
- o_valid  out  1  valid to downstream.
- o_data  out  DWIDTH  downstream payload.
- o_last  out  1  downstream end-of-packet.
- i_ready  in  1  downstream ready.
- i_flush  in  1  synchronous discard of all stored entries.
- o_level  out  $clog2(DEPTH+1)  entries currently stored.
- o_almost_full  out  1  o_level ≥ AFULL_THRESH.

## Operation
- Handshakes:
  - Push when i_valid && o_ready at the clock edge.
  - Pop when o_valid && i_ready at the clock edge.
- Storage:
  - Circular array of DEPTH entries of {last, data}.
  - Write and read pointers are log2(DEPTH) bits and wrap naturally.
  - count is 0..DEPTH.
- Outputs:
  - o_data/o_last = mem[rd_ptr].
  - o_valid = (count != 0), registered.
  - o_ready = (count != DEPTH), registered.
  - o_level = count.
- Simultaneous push and pop:
  - Legal at any count from 1 to DEPTH-1.
  - count is unchanged and both pointers advance.
  - Push and pop cannot coincide at count == DEPTH, because o_ready is low then.
- Empty: no pop is possible. A push makes the data visible on the next cycle; there is no fall-through.
- Full:
  - o_ready is low.
  - A pop at full raises o_ready on the following cycle, so there is one bubble on the push side.
- Ordering: strict FIFO order; last travels with its data word.
- AXI stability: while o_valid && !i_ready, o_data and o_last hold.
- Flush:
  - i_flush has priority over push and pop in the same cycle.
  - A word presented that cycle is discarded, and the upstream sees a completed handshake if o_ready was high.
  - Next cycle: count=0, pointers=0, o_valid=0, o_ready=1, o_level=0, o_almost_full=0.
- Reset mid-operation: all stored content is lost immediately. Array contents are not reset and are don't-care.
- Upstream protocol: the block does not check it. i_data is sampled only on a push.

## Timing
- Reset values while reset_done is high:
  - o_valid=0, o_ready=0, o_level=0, o_almost_full=0.
  - o_data and o_last: don't-care.
- First rising edge after reset_done falls: o_ready=1.
- Latency: a push at edge N gives o_valid=1 after edge N when the buffer was empty.
- Throughput: 1 word/cycle sustained when count < DEPTH.
- o_level and o_almost_full update on the same edge as the push or pop that changes count.

## Structure
- Package axis_skid_pkg:
  - level_width(DEPTH) function (clog2(DEPTH+1)).
  - ptr_width(DEPTH) function.
  - Packed struct type axis_beat_t {last, data} parametrised via DWIDTH in the module (typedef inside the module using the package width helpers).
- Sub-module axis_skid_fifo_ctrl:
  - Owns pointers, count, flush, and the o_valid/o_ready/level/almost_full registers.
  - Top holds the storage array and output mux.
- Elaboration assertions:
  - DEPTH is a power of two and ≥2.
  - AFULL_THRESH is within 1..DEPTH.

## Test plan
- Reset then idle, DWIDTH=8, DEPTH=4:
  - During reset: o_valid=0, o_ready=0.
  - One edge after release: o_ready=1, o_level=0.
- Continuous streaming, i_ready held 1: push 1..16 → o_data reads 1..16 in order, each one cycle after its push, zero bubbles, o_level stays ≤1.
- Fill with i_ready=0: push 1..4.
  - o_ready=0 after 4th push; o_level=4; o_almost_full=1 from level 3 (AFULL_THRESH=3).
  - Single pop returns 1 and o_ready=1 next cycle.
- Random valid/ready (50% each), 2000 cycles, i_last on every 5th word → scoreboard shows no loss, duplication or reorder; o_last on exactly the 5th, 10th, … words; o_data stable during stalls.
- Flush at level 3 with a simultaneous push of 0xAA → next cycle o_valid=0, o_level=0; 0xAA never appears on the output.
- Async reset asserted mid-stream at level 2 → o_valid and o_level drop to 0 without a clock edge; after release a push of 0x55 is the first word out.
